pe_os_multi: RTL

- Next-generation output-stationary MAC processing element for the systolic array.
- Holds NUM_ACC stationary partial sums, selected per operation, so one PE can compute several output pixels or channels.
- Two-stage zero-gated multiply/accumulate pipeline; signed or unsigned operands.
- Drains accumulators over a ready/valid daisy chain toward the array edge, then passes upstream PEs' results through.

---
 rtl/pe_os_multi.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pe_os_multi.sv
// Output-stationary MAC PE: NUM_ACC stationary sums, 2-stage zero-gated MAC, ready/valid drain chain.
// Define OUT_PE_SATURATE_EN to make the stage-2 accumulate saturate instead of wrapping.
module pe_os_multi #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int INPUT_WIDTH  = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int NUM_ACC      = 4,
  parameter int SIGNED       = 0,
  parameter int CHAIN_POS    = 0
) (
  input  logic                        w_clock,
  input  logic                        w_reset,
  input  logic                        w_en,
  input  logic [$clog2(NUM_ACC)-1:0]  w_acc_sel,
  input  logic                        w_clear,
  input  logic [WEIGHT_WIDTH-1:0]     w_weight,
  input  logic [INPUT_WIDTH-1:0]      w_input,
  output logic [WEIGHT_WIDTH-1:0]     w_wgt_out,
  output logic [INPUT_WIDTH-1:0]      w_inp_out,
  output logic                        w_en_out,
  input  logic                        w_drain_start,
  input  logic [ACC_WIDTH-1:0]        w_drain_in,
  input  logic                        w_drain_in_valid,
  output logic                        w_drain_in_ready,
  output logic [ACC_WIDTH-1:0]        w_drain_out,
  output logic                        w_drain_out_valid,
  input  logic                        w_drain_out_ready,
  output logic                        w_busy
);

  localparam int SEL_W      = $clog2(NUM_ACC);
  localparam int PROD_W     = WEIGHT_WIDTH + INPUT_WIDTH;
  localparam int PASS_TOTAL = CHAIN_POS * NUM_ACC;
  localparam int CNT_W      = (PASS_TOTAL < 2) ? 1 : $clog2(PASS_TOTAL + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, PASS} state_t;

  state_t state, state_next;

  logic [ACC_WIDTH-1:0] acc [NUM_ACC];
  logic [ACC_WIDTH-1:0] s1_product;
  logic [SEL_W-1:0]     s1_sel;
  logic                 s1_clear, s1_zero, s1_valid;
  logic [SEL_W-1:0]     idx;
  logic [CNT_W-1:0]     pass_cnt;

  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod_u;
  logic [ACC_WIDTH-1:0]     prod_ext;
  logic                     mac_accept, op_zero;
  logic                     drain_fire, pass_fire;
  logic [ACC_WIDTH-1:0]     add_a, add_b, acc_sum, acc_next;

  assign prod_s     = PROD_W'($signed(w_weight)) * PROD_W'($signed(w_input));
  assign prod_u     = PROD_W'(w_weight) * PROD_W'(w_input);
  assign prod_ext   = (SIGNED != 0) ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);
  assign mac_accept = w_en && (state == IDLE);
  assign op_zero    = (w_weight == '0) || (w_input == '0);
  assign drain_fire = (state == DRAIN) && w_drain_out_ready;
  assign pass_fire  = (state == PASS) && w_drain_in_valid && w_drain_out_ready;
  assign w_busy     = (state != IDLE);

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      w_wgt_out <= '0;
      w_inp_out <= '0;
      w_en_out  <= 1'b0;
    end else begin
      w_wgt_out <= w_weight;
      w_inp_out <= w_input;
      w_en_out  <= w_en;
    end
  end

  // A zero operand leaves the product register untouched; s1_zero makes stage 2 add 0 instead.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      s1_product <= '0;
      s1_sel     <= '0;
      s1_clear   <= 1'b0;
      s1_zero    <= 1'b0;
      s1_valid   <= 1'b0;
    end else begin
      s1_valid <= mac_accept && (!op_zero || w_clear);
      if (mac_accept) begin
        s1_sel   <= w_acc_sel;
        s1_clear <= w_clear;
        s1_zero  <= op_zero;
        if (!op_zero) s1_product <= prod_ext;
      end
    end
  end

  always_comb begin
    add_a    = s1_clear ? '0 : acc[s1_sel];
    add_b    = s1_zero ? '0 : s1_product;
    acc_sum  = add_a + add_b;
    acc_next = acc_sum;
`ifdef OUT_PE_SATURATE_EN
    if (SIGNED != 0) begin
      if ((add_a[ACC_WIDTH-1] == add_b[ACC_WIDTH-1]) && (acc_sum[ACC_WIDTH-1] != add_a[ACC_WIDTH-1]))
        acc_next = add_a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else if (acc_sum < add_a) begin
      acc_next = '1;
    end
`endif
  end

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else begin
      if (s1_valid) acc[s1_sel] <= acc_next;
      if (drain_fire) acc[idx] <= '0;
    end
  end

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      state    <= IDLE;
      idx      <= '0;
      pass_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == FLUSH) idx <= '0;
      else if (drain_fire) idx <= idx + SEL_W'(1);
      if (state == DRAIN) pass_cnt <= '0;
      else if (pass_fire)
        pass_cnt <= (pass_cnt == CNT_W'(PASS_TOTAL - 1)) ? '0 : pass_cnt + CNT_W'(1);
    end
  end

  // FLUSH only needs stage 1 empty: stage 2 writes the accumulator on the edge stage 1 drains.
  always_comb begin
    state_next        = state;
    w_drain_out       = '0;
    w_drain_out_valid = 1'b0;
    w_drain_in_ready  = 1'b0;
    case (state)
      IDLE:  if (w_drain_start) state_next = FLUSH;
      FLUSH: if (!s1_valid) state_next = DRAIN;
      DRAIN: begin
        w_drain_out       = acc[idx];
        w_drain_out_valid = 1'b1;
        if (w_drain_out_ready && (idx == SEL_W'(NUM_ACC - 1)))
          state_next = (CHAIN_POS > 0) ? PASS : IDLE;
      end
      PASS: begin
        w_drain_out       = w_drain_in;
        w_drain_out_valid = w_drain_in_valid;
        w_drain_in_ready  = w_drain_out_ready;
        if (pass_fire && (pass_cnt == CNT_W'(PASS_TOTAL - 1))) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
